// File: rtl/main_fsm_if.sv
// -----------------------------------------------------------------------------
// main_fsm_if
// Control bus between the multicycle main controller and the datapath.
//
// Parameter
//   CNT_W    width of the retired-instruction counter (must match main_fsm)
//
// Signals
//   op_code  [6:0]     opcode of the instruction register       (datapath -> fsm)
//   mem_ack            memory completes the current request     (datapath -> fsm)
//   mem_req            memory request, held until mem_ack       (fsm -> datapath)
//   adr_s              address select: 0 = PC, 1 = ALU result
//   ir_w, pc_w         instruction-register write, PC write
//   branch             branch evaluation cycle
//   jump     [1:0]     01 = sequential, 10 = jal, 11 = trap
//   dato_s   [1:0]     writeback select: 00 ALU, 01 memory, 10 PC+4, 11 CSR
//   mem_w              store strobe
//   alu_a    [1:0]     ALU operand A: 00 PC, 01 old PC, 10 rs1
//   alu_b    [1:0]     ALU operand B: 00 rs2, 01 immediate, 10 constant 4
//   reg_w              register-file write
//   sel      [1:0]     ALU decoder mode: 00 add, 01 branch, 10 funct
//   illegal            trap state active
//   state    [3:0]     current state encoding
//   instret  [CNT_W]   retired-instruction count
//
// Modports
//   master   the controller (drives the control outputs)
//   slave    the datapath / environment (drives op_code and mem_ack)
// -----------------------------------------------------------------------------
interface main_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op_code;
    logic             mem_ack;
    logic             mem_req;
    logic             adr_s;
    logic             ir_w;
    logic             pc_w;
    logic             branch;
    logic [1:0]       jump;
    logic [1:0]       dato_s;
    logic             mem_w;
    logic [1:0]       alu_a;
    logic [1:0]       alu_b;
    logic             reg_w;
    logic [1:0]       sel;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op_code, mem_ack,
        output mem_req, adr_s, ir_w, pc_w, branch, jump, dato_s, mem_w,
               alu_a, alu_b, reg_w, sel, illegal, state, instret
    );

    modport slave (
        output op_code, mem_ack,
        input  mem_req, adr_s, ir_w, pc_w, branch, jump, dato_s, mem_w,
               alu_a, alu_b, reg_w, sel, illegal, state, instret
    );
endinterface

// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm
// Moore control FSM of a multicycle RV32-style processor. Sequences fetch,
// decode, memory access, ALU execute/writeback, branch, jal and CSR steps,
// guards every memory wait with a timeout that lands in a sticky TRAP state,
// and counts retired instructions.
//
// Parameters
//   WAIT_MAX  maximum cycles a memory request may wait for mem_ack (default 15)
//   WAIT_W    width of the wait counter, WAIT_MAX < 2**WAIT_W      (default 4)
//   CNT_W     width of the retired-instruction counter              (default 32)
//
// Ports
//   clk       single clock, all state on the rising edge
//   rst       asynchronous, active-high reset
//   bus       main_fsm_if.master: op_code/mem_ack in, control outputs out
//
// Build option
//   MAIN_FSM_CSR_EN  when defined, opcode 115 executes through the CSR state;
//                    otherwise opcode 115 traps and the CSR state does not exist.
//
// Output timing
//   All control outputs except ir_w/pc_w come from a register loaded with the
//   decode of the next state, so they always match the current state exactly
//   and are glitch-free. ir_w and pc_w in FETCH must follow mem_ack within the
//   same cycle, so that term is the only combinational path to the outputs.
// -----------------------------------------------------------------------------
module main_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic      clk,
    input  logic      rst,
    main_fsm_if.master bus
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC_R = 4'd6,
        ST_EXEC_I = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JAL    = 4'd10,
`ifdef MAIN_FSM_CSR_EN
        ST_CSR    = 4'd11,
`endif
        ST_TRAP   = 4'd12
    } state_e;

    // Registered control word; pc_w here is only the unconditional (JAL) part.
    typedef struct packed {
        logic       mem_req;
        logic       adr_s;
        logic       pc_w;
        logic       branch;
        logic [1:0] jump;
        logic [1:0] dato_s;
        logic       mem_w;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic       reg_w;
        logic [1:0] sel;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_ITYPE  = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
`ifdef MAIN_FSM_CSR_EN
    localparam logic [6:0] OP_SYSTEM = 7'd115;
`endif

    // Moore output table: anything not listed for a state is 0, jump is 01.
    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t ctrl_s;
        ctrl_s      = '0;
        ctrl_s.jump = 2'b01;
        case (st)
            ST_FETCH: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.alu_b   = 2'b10;
            end
            ST_DECODE: begin
                ctrl_s.alu_a = 2'b01;
                ctrl_s.alu_b = 2'b01;
            end
            ST_MEMADR: begin
                ctrl_s.alu_a = 2'b10;
                ctrl_s.alu_b = 2'b01;
            end
            ST_MEMRD: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.adr_s   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_s.dato_s = 2'b01;
                ctrl_s.reg_w  = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.adr_s   = 1'b1;
                ctrl_s.mem_w   = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_s.alu_a = 2'b10;
                ctrl_s.alu_b = 2'b00;
                ctrl_s.sel   = 2'b10;
            end
            ST_EXEC_I: begin
                ctrl_s.alu_a = 2'b10;
                ctrl_s.alu_b = 2'b01;
                ctrl_s.sel   = 2'b10;
            end
            ST_ALUWB: begin
                ctrl_s.dato_s = 2'b00;
                ctrl_s.reg_w  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_s.branch = 1'b1;
                ctrl_s.alu_a  = 2'b10;
                ctrl_s.alu_b  = 2'b00;
                ctrl_s.sel    = 2'b01;
            end
            ST_JAL: begin
                ctrl_s.jump   = 2'b10;
                ctrl_s.pc_w   = 1'b1;
                ctrl_s.reg_w  = 1'b1;
                ctrl_s.dato_s = 2'b10;
            end
`ifdef MAIN_FSM_CSR_EN
            ST_CSR: begin
                ctrl_s.reg_w  = 1'b1;
                ctrl_s.dato_s = 2'b11;
            end
`endif
            ST_TRAP: begin
                ctrl_s.illegal = 1'b1;
                ctrl_s.jump    = 2'b11;
            end
            default: begin
                ctrl_s.jump = 2'b01;
            end
        endcase
        return ctrl_s;
    endfunction

    state_e             state_r;
    state_e             next_s;
    ctrl_t              ctrl_r;
    logic [WAIT_W-1:0]  wait_r;
    logic [CNT_W-1:0]   instret_r;
    logic               mem_req_s;
    logic               timeout_s;
    logic               retire_s;
    logic               fetch_ack_s;

    // Memory-request states and the wait timeout derived from the current state.
    always_comb begin
        mem_req_s   = 1'b0;
        fetch_ack_s = 1'b0;
        if ((state_r == ST_FETCH) || (state_r == ST_MEMRD) || (state_r == ST_MEMWR)) begin
            mem_req_s = 1'b1;
        end else begin
            mem_req_s = 1'b0;
        end
        if (state_r == ST_FETCH) begin
            fetch_ack_s = bus.mem_ack;
        end else begin
            fetch_ack_s = 1'b0;
        end
        // An acknowledge in the limit cycle wins over the timeout.
        timeout_s = mem_req_s && !bus.mem_ack && (wait_r == WAIT_W'(WAIT_MAX));
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    next_s = ST_DECODE;
                end else if (timeout_s) begin
                    next_s = ST_TRAP;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (bus.op_code)
                    OP_LOAD, OP_STORE: next_s = ST_MEMADR;
                    OP_RTYPE:          next_s = ST_EXEC_R;
                    OP_ITYPE:          next_s = ST_EXEC_I;
                    OP_BRANCH:         next_s = ST_BRANCH;
                    OP_JAL:            next_s = ST_JAL;
`ifdef MAIN_FSM_CSR_EN
                    OP_SYSTEM:         next_s = ST_CSR;
`endif
                    default:           next_s = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                if (bus.op_code == OP_LOAD) begin
                    next_s = ST_MEMRD;
                end else begin
                    next_s = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                if (bus.mem_ack) begin
                    next_s = ST_MEMWB;
                end else if (timeout_s) begin
                    next_s = ST_TRAP;
                end else begin
                    next_s = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (bus.mem_ack) begin
                    next_s = ST_FETCH;
                end else if (timeout_s) begin
                    next_s = ST_TRAP;
                end else begin
                    next_s = ST_MEMWR;
                end
            end
            ST_MEMWB:  next_s = ST_FETCH;
            ST_EXEC_R: next_s = ST_ALUWB;
            ST_EXEC_I: next_s = ST_ALUWB;
            ST_ALUWB:  next_s = ST_FETCH;
            ST_BRANCH: next_s = ST_FETCH;
            ST_JAL:    next_s = ST_FETCH;
`ifdef MAIN_FSM_CSR_EN
            ST_CSR:    next_s = ST_FETCH;
`endif
            ST_TRAP:   next_s = ST_TRAP;
            // Unused encodings fall into the trap.
            default:   next_s = ST_TRAP;
        endcase
        // Only an instruction that completes normally counts as retired.
        retire_s = (next_s == ST_FETCH) && (state_r != ST_FETCH) && (state_r != ST_TRAP);
    end

    // State register and registered control word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
            ctrl_r  <= decode_ctrl(ST_FETCH);
        end else begin
            state_r <= next_s;
            ctrl_r  <= decode_ctrl(next_s);
        end
    end

    // Memory wait counter; any state change restarts it, so every request
    // state is entered with a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_r <= '0;
        end else if ((next_s != state_r) || bus.mem_ack) begin
            wait_r <= '0;
        end else if (mem_req_s) begin
            wait_r <= wait_r + WAIT_W'(1);
        end else begin
            wait_r <= wait_r;
        end
    end

    // Retired-instruction counter, wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign bus.mem_req = ctrl_r.mem_req;
    assign bus.adr_s   = ctrl_r.adr_s;
    assign bus.ir_w    = fetch_ack_s;
    assign bus.pc_w    = ctrl_r.pc_w | fetch_ack_s;
    assign bus.branch  = ctrl_r.branch;
    assign bus.jump    = ctrl_r.jump;
    assign bus.dato_s  = ctrl_r.dato_s;
    assign bus.mem_w   = ctrl_r.mem_w;
    assign bus.alu_a   = ctrl_r.alu_a;
    assign bus.alu_b   = ctrl_r.alu_b;
    assign bus.reg_w   = ctrl_r.reg_w;
    assign bus.sel     = ctrl_r.sel;
    assign bus.illegal = ctrl_r.illegal;
    assign bus.state   = state_r;
    assign bus.instret = instret_r;

endmodule

// File: tb/tb_main_fsm.sv
`timescale 1ns/1ps
module tb_main_fsm;
    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;
    localparam int CNT_W    = 4;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_EXEC_R = 6, P_EXEC_I = 7, P_ALUWB = 8, P_BRANCH = 9;
    localparam int P_JAL = 10, P_CSR = 11, P_TRAP = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    main_fsm_if #(.CNT_W(CNT_W)) bus ();

    main_fsm #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [25:0] exp_q[$];
    int          tag_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          instret_m = 0;

    // Expected observable response for one cycle spent in a given step of an
    // instruction, straight from the control table of the processor.
    function automatic logic [25:0] exp_vec(input int st, input logic ack, input int cnt);
        logic       mem_req, adr_s, ir_w, pc_w, branch, mem_w, reg_w, illegal;
        logic [1:0] jump, dato_s, alu_a, alu_b, sel;
        mem_req = 1'b0; adr_s = 1'b0; ir_w = 1'b0; pc_w = 1'b0; branch = 1'b0;
        mem_w = 1'b0; reg_w = 1'b0; illegal = 1'b0;
        jump = 2'b01; dato_s = 2'b00; alu_a = 2'b00; alu_b = 2'b00; sel = 2'b00;
        case (st)
            P_FETCH:  begin mem_req = 1'b1; alu_b = 2'b10; ir_w = ack; pc_w = ack; end
            P_DECODE: begin alu_a = 2'b01; alu_b = 2'b01; end
            P_MEMADR: begin alu_a = 2'b10; alu_b = 2'b01; end
            P_MEMRD:  begin mem_req = 1'b1; adr_s = 1'b1; end
            P_MEMWB:  begin dato_s = 2'b01; reg_w = 1'b1; end
            P_MEMWR:  begin mem_req = 1'b1; adr_s = 1'b1; mem_w = 1'b1; end
            P_EXEC_R: begin alu_a = 2'b10; alu_b = 2'b00; sel = 2'b10; end
            P_EXEC_I: begin alu_a = 2'b10; alu_b = 2'b01; sel = 2'b10; end
            P_ALUWB:  begin reg_w = 1'b1; end
            P_BRANCH: begin branch = 1'b1; alu_a = 2'b10; sel = 2'b01; end
            P_JAL:    begin jump = 2'b10; pc_w = 1'b1; reg_w = 1'b1; dato_s = 2'b10; end
            P_CSR:    begin reg_w = 1'b1; dato_s = 2'b11; end
            P_TRAP:   begin illegal = 1'b1; jump = 2'b11; end
            default:  begin end
        endcase
        return {4'(st), mem_req, adr_s, ir_w, pc_w, branch, jump, dato_s, mem_w,
                alu_a, alu_b, reg_w, sel, illegal, 4'(cnt)};
    endfunction

    // Monitor: compares every presented cycle against the scoreboard head.
    logic [25:0] mon_exp, mon_act;
    int          mon_tag;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {bus.state, bus.mem_req, bus.adr_s, bus.ir_w, bus.pc_w, bus.branch,
                       bus.jump, bus.dato_s, bus.mem_w, bus.alu_a, bus.alu_b, bus.reg_w,
                       bus.sel, bus.illegal, bus.instret};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL step_state%0d at %0t: got %h expected %h (state/ctrl/instret)",
                         mon_tag, $time, mon_act, mon_exp);
            end
        end
    end

    // Direct check of one observed value against its expected value.
    task automatic check_val(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", what, $time, got, exp);
        end
    endtask

    // One cycle of stimulus: drive mem_ack, record what the bus must show.
    task automatic step(input int st, input logic ack);
        bus.mem_ack = ack;
        exp_q.push_back(exp_vec(st, ack, instret_m));
        tag_q.push_back(st);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_ack();
        return logic'($urandom_range(0, 1));
    endfunction

    // A memory wait of d idle cycles; past WAIT_MAX idle cycles it traps.
    task automatic mem_phase(input int st, input int d, output bit trapped);
        trapped = 1'b0;
        for (int k = 0; k <= WAIT_MAX; k++) begin
            if (k == d) begin
                step(st, 1'b1);
                return;
            end
            step(st, 1'b0);
        end
        trapped = 1'b1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.mem_ack = 1'b0;
        instret_m   = 0;
        step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b0);
        rst = 1'b0;
        check_val("reset_state", 32'(bus.state), 32'(P_FETCH));
        check_val("reset_instret", 32'(bus.instret), 32'd0);
        check_val("reset_mem_req", 32'(bus.mem_req), 32'd1);
    endtask

    // Whole instruction: fetch wait df, memory wait dm.
    task automatic run_instr(input logic [6:0] op, input int df, input int dm);
        bit tr;
        bus.op_code = op;
        mem_phase(P_FETCH, df, tr);
        if (!tr) begin
            step(P_DECODE, rnd_ack());
            case (op)
                7'd3: begin
                    step(P_MEMADR, 1'b0);
                    mem_phase(P_MEMRD, dm, tr);
                    if (!tr) step(P_MEMWB, rnd_ack());
                end
                7'd35: begin
                    step(P_MEMADR, 1'b0);
                    mem_phase(P_MEMWR, dm, tr);
                end
                7'd51:  begin step(P_EXEC_R, rnd_ack()); step(P_ALUWB, rnd_ack()); end
                7'd19:  begin step(P_EXEC_I, rnd_ack()); step(P_ALUWB, rnd_ack()); end
                7'd99:  step(P_BRANCH, rnd_ack());
                7'd111: step(P_JAL, rnd_ack());
`ifdef MAIN_FSM_CSR_EN
                7'd115: step(P_CSR, rnd_ack());
`else
                7'd115: tr = 1'b1;
`endif
                default: tr = 1'b1;
            endcase
        end
        if (tr) begin
            for (int i = 0; i < 3; i++) step(P_TRAP, rnd_ack());
            check_val("trap_state", 32'(bus.state), 32'(P_TRAP));
            check_val("trap_illegal", 32'(bus.illegal), 32'd1);
            check_val("trap_jump", 32'(bus.jump), 32'd3);
            do_reset();
        end else begin
            instret_m = (instret_m + 1) % (1 << CNT_W);
        end
    endtask

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return WAIT_MAX + 1;
        if (r == 1) return WAIT_MAX;
        return int'($urandom_range(0, 3));
    endfunction

    logic [6:0] legal_ops [8];
    initial begin
        logic [6:0] op;
        bus.op_code = 7'd0;
        bus.mem_ack = 1'b0;
        legal_ops[0] = 7'd3;  legal_ops[1] = 7'd35; legal_ops[2] = 7'd51;
        legal_ops[3] = 7'd19; legal_ops[4] = 7'd99; legal_ops[5] = 7'd111;
        legal_ops[6] = 7'd115; legal_ops[7] = 7'd0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(7'd3, 0, 0);              // lw, immediate acks
        run_instr(7'd35, 0, 3);             // sw, MEMWR held 4 cycles
        run_instr(7'd51, WAIT_MAX, 0);      // ack exactly at the limit
        run_instr(7'd3, 1, WAIT_MAX);
        run_instr(7'd115, 0, 0);            // CSR or trap depending on build
        run_instr(7'd51, WAIT_MAX + 1, 0);  // fetch timeout
        run_instr(7'd3, 0, WAIT_MAX + 1);   // load timeout
        run_instr(7'd42, 0, 0);             // illegal opcode

        // Counter wrap across 2**CNT_W retirements.
        for (int i = 0; i < 18; i++) run_instr(7'd51, 0, 0);

        // Reset in the middle of a load wait.
        run_instr(7'd19, 0, 0);
        bus.op_code = 7'd3;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        step(P_MEMADR, 1'b0);
        step(P_MEMRD, 1'b0);
        step(P_MEMRD, 1'b0);
        do_reset();
        run_instr(7'd111, 0, 0);

        // Randomized mix.
        for (int i = 0; i < 80; i++) begin
            op = legal_ops[$urandom_range(0, 7)];
            if (op == 7'd0) begin
                op = 7'($urandom_range(0, 127));
                if (op == 7'd3 || op == 7'd35 || op == 7'd51 || op == 7'd19 ||
                    op == 7'd99 || op == 7'd111 || op == 7'd115) op = 7'd127;
            end
            run_instr(op, rnd_delay(), rnd_delay());
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of cycles a memory request may wait for mem_ack before a trap.
REQ-002 SHALL have parameter WAIT_W, default 4, meaning the width of the wait counter; WAIT_MAX < 2^WAIT_W.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_code  in  7  opcode of the instruction register.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ack.
- adr_s  out  1  address select: 0 = PC, 1 = ALU result.
- ir_w, pc_w  out  1 each  instruction-register write and PC write.
- branch  out  1  branch evaluation cycle.
- jump  out  2  01 = sequential, 10 = jal, 11 = trap.
- dato_s  out  2  writeback select: 00 = ALU, 01 = memory, 10 = PC+4, 11 = CSR.
- mem_w  out  1  store strobe.
- alu_a  out  2  ALU operand A: 00 = PC, 01 = old PC, 10 = rs1.
- alu_b  out  2  ALU operand B: 00 = rs2, 01 = immediate, 10 = constant 4.
- reg_w  out  1  register-file write.
- sel  out  2  ALU decoder mode: 00 = add, 01 = branch, 10 = funct.
- illegal  out  1  trap state active.
- state  out  4  current state encoding.
- instret  out  CNT_W  retired-instruction count.

Function
REQ-005 SHALL be a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, CSR=11, TRAP=12. Codes 13-15 SHALL go to TRAP on the next cycle.
REQ-006 SHALL drive every output not listed for the current state to 0, except jump, which defaults to 01.
REQ-007 FETCH SHALL drive mem_req=1, adr_s=0, alu_a=00, alu_b=10 and sel=00. ir_w and pc_w SHALL equal mem_ack. On mem_ack the FSM SHALL go to DECODE; otherwise it SHALL stay in FETCH.
REQ-008 DECODE SHALL drive alu_a=01, alu_b=01 and sel=00, then go to the next state by opcode: 3 or 35 -> MEMADR; 51 -> EXEC_R; 19 -> EXEC_I; 99 -> BRANCH; 111 -> JAL; 115 -> CSR; any other opcode -> TRAP.
REQ-009 MEMADR SHALL drive alu_a=10, alu_b=01 and sel=00, then go to MEMRD if op_code=3, else to MEMWR.
REQ-010 MEMRD SHALL drive mem_req=1 and adr_s=1, and go to MEMWB on mem_ack. MEMWR SHALL drive mem_req=1, adr_s=1 and mem_w=1, and go to FETCH on mem_ack.
REQ-011 MEMWB SHALL drive dato_s=01 and reg_w=1, then go to FETCH.
REQ-012 EXEC_R SHALL drive alu_a=10, alu_b=00 and sel=10. EXEC_I SHALL drive alu_a=10, alu_b=01 and sel=10. Both SHALL go to ALUWB.
REQ-013 ALUWB SHALL drive dato_s=00 and reg_w=1, then go to FETCH.
REQ-014 BRANCH SHALL drive branch=1, alu_a=10, alu_b=00 and sel=01, then go to FETCH.
REQ-015 JAL SHALL drive jump=10, pc_w=1, reg_w=1 and dato_s=10, then go to FETCH.
REQ-016 CSR SHALL drive reg_w=1 and dato_s=11, then go to FETCH.
REQ-017 TRAP SHALL drive illegal=1 and jump=11 with every write strobe at 0, and SHALL stay in TRAP until rst.
REQ-018 The wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and on mem_ack. It SHALL increment each cycle mem_req=1 and mem_ack=0. When mem_ack=0 and the count equals WAIT_MAX, the FSM SHALL go to TRAP. mem_ack in that same cycle SHALL take priority over the timeout.
REQ-019 instret SHALL increment by 1 on every transition into FETCH from a non-TRAP state, and SHALL wrap modulo 2^CNT_W.

Reset
REQ-020 While rst=1, state SHALL be FETCH, the wait counter 0 and instret 0, asynchronously. This applies mid-wait and from TRAP.
REQ-021 After rst deasserts, mem_req SHALL be 1 in the first cycle and all write strobes except the ack-gated ir_w/pc_w SHALL be 0.

Configuration
REQ-022 With macro MAIN_FSM_CSR_EN defined, opcode 115 SHALL go DECODE -> CSR. Without it, opcode 115 SHALL go to TRAP and the CSR state SHALL be absent.

Verification
REQ-023 lw: op_code=3, mem_ack=1 in each memory state -> states 0,1,2,3,4,0; reg_w=1 with dato_s=01 in state 4; instret=1.
REQ-024 sw with mem_ack delayed 3 cycles: op_code=35 -> MEMWR held 4 cycles; mem_w=1 throughout; reg_w never 1.
REQ-025 Timeout: mem_ack=0 held in FETCH -> TRAP after WAIT_MAX+1=16 cycles; illegal=1 and jump=11 until rst.
REQ-026 op_code=115: with MAIN_FSM_CSR_EN -> state 11 with dato_s=11; without it -> state 12.
REQ-027 Preload instret near 2^CNT_W-1 (CNT_W=4 build), run 2 R-type instructions -> instret wraps 15 -> 0.
REQ-028 Assert rst mid-MEMRD -> state=0, instret=0 and mem_req=1 in the cycle after release.
